ctrl_pipe_regs: RTL and testbench

- Carries the decode-stage control word through the E, M and W stages of the 5-stage RV32I pipeline.
- Input is the combinational control decoder's output.
- Outputs feed the ALU, data memory, writeback mux, hazard unit and PC mux.
- Also generates the E-stage PC-source select and counts retired instructions.

---
 rtl/ctrl_pipe_regs.sv | 153 +++++++++++++++
 tb/tb_ctrl_pipe_regs.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipe_regs.sv
// ctrl_pipe_regs: carries the decoded control word from D through the E, M
// and W stages of the 5-stage RV32I pipeline. It also forms the E-stage
// PC-source select and counts the instructions that retire out of W.
//
// Ports
//   i_clk, i_rst_n        rising-edge clock, asynchronous active-low reset
//   i_*_d                 control word from the combinational decoder (D stage)
//   i_flush_e             load a bubble into E at the next edge
//   i_zero_e              ALU zero flag for the instruction currently in E
//   o_*_e                 E-stage controls (ALU, hazard unit, PC mux)
//   o_*_m                 M-stage controls (data memory, forwarding)
//   o_*_w                 W-stage controls (register file, writeback mux)
//   o_retired             running count of valid instructions leaving W
module ctrl_pipe_regs #(
    parameter int unsigned REG_W = 5,
    parameter int unsigned CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid_d,
    input  logic [1:0]       i_result_src_d,
    input  logic             i_mem_write_d,
    input  logic             i_reg_write_d,
    input  logic             i_jmp_d,
    input  logic             i_branch_d,
    input  logic [1:0]       i_alu_op_d,
    input  logic             i_alu_src_d,
    input  logic [REG_W-1:0] i_rd_d,
    input  logic             i_flush_e,
    input  logic             i_zero_e,
    output logic [1:0]       o_alu_op_e,
    output logic             o_alu_src_e,
    output logic [REG_W-1:0] o_rd_e,
    output logic             o_load_e,
    output logic             o_pc_src_e,
    output logic             o_mem_write_m,
    output logic             o_reg_write_m,
    output logic [REG_W-1:0] o_rd_m,
    output logic [1:0]       o_result_src_m,
    output logic             o_reg_write_w,
    output logic [REG_W-1:0] o_rd_w,
    output logic [1:0]       o_result_src_w,
    output logic [CNT_W-1:0] o_retired
);

    localparam logic [1:0] RESULT_MEM = 2'b01;

    // Each bank keeps only the fields that later stages still consume.
    typedef struct packed {
        logic             valid;
        logic [1:0]       result_src;
        logic             mem_write;
        logic             reg_write;
        logic             jmp;
        logic             branch;
        logic [1:0]       alu_op;
        logic             alu_src;
        logic [REG_W-1:0] rd;
    } stage_e_t;

    typedef struct packed {
        logic             valid;
        logic [1:0]       result_src;
        logic             mem_write;
        logic             reg_write;
        logic [REG_W-1:0] rd;
    } stage_m_t;

    typedef struct packed {
        logic             valid;
        logic [1:0]       result_src;
        logic             reg_write;
        logic [REG_W-1:0] rd;
    } stage_w_t;

    stage_e_t         e_q, e_d;
    stage_m_t         m_q, m_d;
    stage_w_t         w_q, w_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    // Next-state for all three banks and the retirement counter.
    always_comb begin
        e_d       = '0;
        m_d       = '0;
        w_d       = '0;
        retired_d = retired_q;

        // Flush wins over a valid instruction; either way E becomes an all-zero bubble.
        if (i_valid_d && !i_flush_e) begin
            e_d.valid      = 1'b1;
            e_d.result_src = i_result_src_d;
            e_d.mem_write  = i_mem_write_d;
            // A write to x0 is dropped here so it never reaches forwarding or the RF.
            e_d.reg_write  = i_reg_write_d && (i_rd_d != '0);
            e_d.jmp        = i_jmp_d;
            e_d.branch     = i_branch_d;
            e_d.alu_op     = i_alu_op_d;
            e_d.alu_src    = i_alu_src_d;
            e_d.rd         = i_rd_d;
        end

        m_d.valid      = e_q.valid;
        m_d.result_src = e_q.result_src;
        m_d.mem_write  = e_q.mem_write;
        m_d.reg_write  = e_q.reg_write;
        m_d.rd         = e_q.rd;

        w_d.valid      = m_q.valid;
        w_d.result_src = m_q.result_src;
        w_d.reg_write  = m_q.reg_write;
        w_d.rd         = m_q.rd;

        // Natural modulo-2^CNT_W wrap.
        if (w_q.valid) begin
            retired_d = retired_q + CNT_W'(1);
        end
    end

    // Stage registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            e_q       <= '0;
            m_q       <= '0;
            w_q       <= '0;
            retired_q <= '0;
        end else begin
            e_q       <= e_d;
            m_q       <= m_d;
            w_q       <= w_d;
            retired_q <= retired_d;
        end
    end

    // E-stage outputs; PC select is combinational because i_zero_e arrives late in E.
    assign o_alu_op_e  = e_q.alu_op;
    assign o_alu_src_e = e_q.alu_src;
    assign o_rd_e      = e_q.rd;
    assign o_load_e    = e_q.valid && (e_q.result_src == RESULT_MEM);
    assign o_pc_src_e  = e_q.valid && (e_q.jmp || (e_q.branch && i_zero_e));

    // M-stage outputs.
    assign o_mem_write_m  = m_q.valid && m_q.mem_write;
    assign o_reg_write_m  = m_q.valid && m_q.reg_write;
    assign o_rd_m         = m_q.rd;
    assign o_result_src_m = m_q.result_src;

    // W-stage outputs.
    assign o_reg_write_w  = w_q.valid && w_q.reg_write;
    assign o_rd_w         = w_q.rd;
    assign o_result_src_w = w_q.result_src;
    assign o_retired      = retired_q;

endmodule

// File: tb/tb_ctrl_pipe_regs.sv
// Scoreboard bench for ctrl_pipe_regs: stimulus pushes expected (cycle, signal,
// value) entries, and a negedge monitor pops and compares those due this cycle.
module tb_ctrl_pipe_regs;

    localparam int SIG_ALU_OP_E     = 0;
    localparam int SIG_ALU_SRC_E    = 1;
    localparam int SIG_RD_E         = 2;
    localparam int SIG_LOAD_E       = 3;
    localparam int SIG_PC_SRC_E     = 4;
    localparam int SIG_MEM_WRITE_M  = 5;
    localparam int SIG_REG_WRITE_M  = 6;
    localparam int SIG_RD_M         = 7;
    localparam int SIG_RESULT_SRC_M = 8;
    localparam int SIG_REG_WRITE_W  = 9;
    localparam int SIG_RD_W         = 10;
    localparam int SIG_RESULT_SRC_W = 11;
    localparam int SIG_RETIRED      = 12;
    localparam int SIG_RETIRED4     = 13;
    localparam int NUM_SIGS         = 14;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_d, mem_write_d, reg_write_d, jmp_d, branch_d, alu_src_d;
    logic [1:0]  result_src_d, alu_op_d;
    logic [4:0]  rd_d;
    logic        flush_e, zero_e;

    logic [1:0]  alu_op_e, result_src_m, result_src_w;
    logic        alu_src_e, load_e, pc_src_e, mem_write_m, reg_write_m, reg_write_w;
    logic [4:0]  rd_e, rd_m, rd_w;
    logic [31:0] retired;

    logic [1:0]  b_alu_op_e, b_result_src_m, b_result_src_w;
    logic        b_alu_src_e, b_load_e, b_pc_src_e, b_mem_write_m, b_reg_write_m, b_reg_write_w;
    logic [4:0]  b_rd_e, b_rd_m, b_rd_w;
    logic [3:0]  retired4;

    ctrl_pipe_regs #(.REG_W(5), .CNT_W(32)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid_d(valid_d), .i_result_src_d(result_src_d),
        .i_mem_write_d(mem_write_d), .i_reg_write_d(reg_write_d), .i_jmp_d(jmp_d),
        .i_branch_d(branch_d), .i_alu_op_d(alu_op_d), .i_alu_src_d(alu_src_d), .i_rd_d(rd_d),
        .i_flush_e(flush_e), .i_zero_e(zero_e),
        .o_alu_op_e(alu_op_e), .o_alu_src_e(alu_src_e), .o_rd_e(rd_e), .o_load_e(load_e),
        .o_pc_src_e(pc_src_e), .o_mem_write_m(mem_write_m), .o_reg_write_m(reg_write_m),
        .o_rd_m(rd_m), .o_result_src_m(result_src_m), .o_reg_write_w(reg_write_w),
        .o_rd_w(rd_w), .o_result_src_w(result_src_w), .o_retired(retired)
    );

    // Narrow-counter instance for the wrap check; shares all inputs.
    ctrl_pipe_regs #(.REG_W(5), .CNT_W(4)) dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid_d(valid_d), .i_result_src_d(result_src_d),
        .i_mem_write_d(mem_write_d), .i_reg_write_d(reg_write_d), .i_jmp_d(jmp_d),
        .i_branch_d(branch_d), .i_alu_op_d(alu_op_d), .i_alu_src_d(alu_src_d), .i_rd_d(rd_d),
        .i_flush_e(flush_e), .i_zero_e(zero_e),
        .o_alu_op_e(b_alu_op_e), .o_alu_src_e(b_alu_src_e), .o_rd_e(b_rd_e), .o_load_e(b_load_e),
        .o_pc_src_e(b_pc_src_e), .o_mem_write_m(b_mem_write_m), .o_reg_write_m(b_reg_write_m),
        .o_rd_m(b_rd_m), .o_result_src_m(b_result_src_m), .o_reg_write_w(b_reg_write_w),
        .o_rd_w(b_rd_w), .o_result_src_w(b_result_src_w), .o_retired(retired4)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    typedef struct {
        int          cyc;
        int          sig;
        logic [31:0] exp;
        string       tag;
    } chk_t;

    chk_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic string sig_name(input int id);
        case (id)
            SIG_ALU_OP_E:     return "alu_op_e";
            SIG_ALU_SRC_E:    return "alu_src_e";
            SIG_RD_E:         return "rd_e";
            SIG_LOAD_E:       return "load_e";
            SIG_PC_SRC_E:     return "pc_src_e";
            SIG_MEM_WRITE_M:  return "mem_write_m";
            SIG_REG_WRITE_M:  return "reg_write_m";
            SIG_RD_M:         return "rd_m";
            SIG_RESULT_SRC_M: return "result_src_m";
            SIG_REG_WRITE_W:  return "reg_write_w";
            SIG_RD_W:         return "rd_w";
            SIG_RESULT_SRC_W: return "result_src_w";
            SIG_RETIRED:      return "retired";
            default:          return "retired4";
        endcase
    endfunction

    function automatic logic [31:0] get_sig(input int id);
        case (id)
            SIG_ALU_OP_E:     return 32'(alu_op_e);
            SIG_ALU_SRC_E:    return 32'(alu_src_e);
            SIG_RD_E:         return 32'(rd_e);
            SIG_LOAD_E:       return 32'(load_e);
            SIG_PC_SRC_E:     return 32'(pc_src_e);
            SIG_MEM_WRITE_M:  return 32'(mem_write_m);
            SIG_REG_WRITE_M:  return 32'(reg_write_m);
            SIG_RD_M:         return 32'(rd_m);
            SIG_RESULT_SRC_M: return 32'(result_src_m);
            SIG_REG_WRITE_W:  return 32'(reg_write_w);
            SIG_RD_W:         return 32'(rd_w);
            SIG_RESULT_SRC_W: return 32'(result_src_w);
            SIG_RETIRED:      return retired;
            default:          return 32'(retired4);
        endcase
    endfunction

    // Monitor: compare every scoreboard entry due at this cycle.
    always @(negedge clk) begin
        logic [31:0] act;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc <= edge_cnt) begin
                act = get_sig(sb[i].sig);
                n_checks++;
                if (sb[i].cyc < edge_cnt)
                    $display("FAIL %s.%s: check for cycle %0d missed", sb[i].tag,
                             sig_name(sb[i].sig), sb[i].cyc);
                else if (act === sb[i].exp)
                    n_pass++;
                else
                    $display("FAIL %s.%s @cycle %0d: got %0h expected %0h", sb[i].tag,
                             sig_name(sb[i].sig), edge_cnt, act, sb[i].exp);
                sb.delete(i);
            end
        end
    end

    task automatic expect_at(input int dcyc, input int sig, input logic [31:0] v, input string tag);
        chk_t c;
        c.cyc = edge_cnt + dcyc;
        c.sig = sig;
        c.exp = v;
        c.tag = tag;
        sb.push_back(c);
    endtask

    task automatic expect_all_zero(input int dcyc, input string tag);
        for (int s = 0; s < NUM_SIGS; s++) expect_at(dcyc, s, 32'd0, tag);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic v, input logic [1:0] rs, input logic mw, input logic rw,
                         input logic jmp, input logic br, input logic [1:0] aop,
                         input logic asrc, input logic [4:0] rd, input logic fl);
        valid_d      = v;
        result_src_d = rs;
        mem_write_d  = mw;
        reg_write_d  = rw;
        jmp_d        = jmp;
        branch_d     = br;
        alu_op_d     = aop;
        alu_src_d    = asrc;
        rd_d         = rd;
        flush_e      = fl;
    endtask

    task automatic nop();
        issue(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic add_x5();
        issue(1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 5'd5, 1'b0);
    endtask

    initial begin
        rst_n  = 1'b0;
        zero_e = 1'b0;
        nop();

        // Reset, then idle.
        step(); step();
        expect_all_zero(0, "in_reset");
        step();
        rst_n = 1'b1;
        repeat (10) step();
        expect_all_zero(0, "idle");

        // R-type add x5 through all stages.
        add_x5();
        expect_at(1, SIG_ALU_OP_E, 32'd2, "add");
        expect_at(1, SIG_RD_E, 32'd5, "add");
        expect_at(1, SIG_ALU_SRC_E, 32'd0, "add");
        expect_at(1, SIG_LOAD_E, 32'd0, "add");
        expect_at(2, SIG_REG_WRITE_M, 32'd1, "add");
        expect_at(2, SIG_RD_M, 32'd5, "add");
        expect_at(2, SIG_MEM_WRITE_M, 32'd0, "add");
        expect_at(3, SIG_REG_WRITE_W, 32'd1, "add");
        expect_at(3, SIG_RD_W, 32'd5, "add");
        expect_at(3, SIG_RESULT_SRC_W, 32'd0, "add");
        expect_at(3, SIG_RETIRED, 32'd0, "add");
        expect_at(4, SIG_RETIRED, 32'd1, "add");
        expect_at(4, SIG_RETIRED4, 32'd1, "add");
        step(); nop(); repeat (5) step();

        // beq (zero=1 then zero=0), jal, then a flushed slot.
        issue(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 5'd0, 1'b0);
        step();
        issue(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 5'd0, 1'b0);
        zero_e = 1'b1;
        expect_at(0, SIG_PC_SRC_E, 32'd1, "beq_z1");
        step();
        issue(1'b1, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 5'd1, 1'b0);
        zero_e = 1'b0;
        expect_at(0, SIG_PC_SRC_E, 32'd0, "beq_z0");
        step();
        issue(1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 5'd7, 1'b1);
        expect_at(0, SIG_PC_SRC_E, 32'd1, "jal");
        expect_at(0, SIG_RD_E, 32'd1, "jal");
        expect_at(1, SIG_RD_E, 32'd0, "flush");
        expect_at(1, SIG_ALU_SRC_E, 32'd0, "flush");
        expect_at(2, SIG_REG_WRITE_W, 32'd1, "jal");
        expect_at(2, SIG_RESULT_SRC_W, 32'd2, "jal");
        expect_at(2, SIG_RD_W, 32'd1, "jal");
        expect_at(3, SIG_REG_WRITE_W, 32'd0, "flush");
        expect_at(3, SIG_RD_W, 32'd0, "flush");
        expect_at(2, SIG_RETIRED, 32'd3, "br_seq");
        expect_at(3, SIG_RETIRED, 32'd4, "br_seq");
        expect_at(4, SIG_RETIRED, 32'd4, "flush_no_retire");
        step();
        nop();
        zero_e = 1'b1;
        expect_at(0, SIG_PC_SRC_E, 32'd0, "bubble_z1");
        step();
        zero_e = 1'b0;
        repeat (4) step();

        // lw x3 followed by a flushed valid instruction.
        issue(1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 5'd3, 1'b0);
        expect_at(1, SIG_LOAD_E, 32'd1, "lw");
        expect_at(1, SIG_RD_E, 32'd3, "lw");
        expect_at(1, SIG_ALU_SRC_E, 32'd1, "lw");
        step();
        issue(1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 1'b1, 5'd9, 1'b1);
        expect_at(1, SIG_LOAD_E, 32'd0, "lw_bubble");
        expect_at(1, SIG_RD_E, 32'd0, "lw_bubble");
        expect_at(1, SIG_ALU_SRC_E, 32'd0, "lw_bubble");
        expect_at(1, SIG_ALU_OP_E, 32'd0, "lw_bubble");
        expect_at(1, SIG_RESULT_SRC_M, 32'd1, "lw");
        expect_at(1, SIG_RD_M, 32'd3, "lw");
        expect_at(2, SIG_RESULT_SRC_W, 32'd1, "lw");
        expect_at(2, SIG_RD_W, 32'd3, "lw");
        expect_at(2, SIG_REG_WRITE_M, 32'd0, "lw_bubble");
        expect_at(2, SIG_RD_M, 32'd0, "lw_bubble");
        expect_at(3, SIG_REG_WRITE_W, 32'd0, "lw_bubble");
        expect_at(3, SIG_RETIRED, 32'd5, "lw");
        expect_at(4, SIG_RETIRED, 32'd5, "lw_bubble");
        step(); nop(); repeat (5) step();

        // addi x0: write never propagates, still retires.
        issue(1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 5'd0, 1'b0);
        expect_at(2, SIG_REG_WRITE_M, 32'd0, "x0");
        expect_at(3, SIG_REG_WRITE_W, 32'd0, "x0");
        expect_at(4, SIG_RETIRED, 32'd6, "x0");
        step(); nop(); repeat (5) step();

        // Asynchronous reset with three instructions in flight.
        add_x5();
        step();
        issue(1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 5'd3, 1'b0);
        step();
        issue(1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 5'd0, 1'b0);
        expect_at(0, SIG_REG_WRITE_M, 32'd1, "inflight");
        expect_at(0, SIG_RETIRED, 32'd6, "inflight");
        step();
        nop();
        #2;
        rst_n = 1'b0;
        expect_all_zero(0, "mid_rst");
        step();
        rst_n = 1'b1;
        issue(1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 5'd0, 1'b0);
        expect_at(1, SIG_MEM_WRITE_M, 32'd0, "sw");
        expect_at(2, SIG_MEM_WRITE_M, 32'd1, "sw");
        expect_at(3, SIG_MEM_WRITE_M, 32'd0, "sw");
        expect_at(4, SIG_RETIRED, 32'd1, "sw");
        step(); nop(); repeat (5) step();

        // Counter wrap on the 4-bit instance: 16 retirements from zero.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        expect_at(18, SIG_RETIRED4, 32'd15, "wrap");
        expect_at(18, SIG_RETIRED, 32'd15, "wrap");
        expect_at(19, SIG_RETIRED4, 32'd0, "wrap");
        expect_at(19, SIG_RETIRED, 32'd16, "wrap");
        for (int k = 0; k < 16; k++) begin
            add_x5();
            step();
        end
        nop();
        repeat (8) step();
        expect_at(0, SIG_RETIRED4, 32'd0, "wrap_idle");
        expect_at(0, SIG_RETIRED, 32'd16, "wrap_idle");
        repeat (3) step();

        // Anything still queued was never compared.
        foreach (sb[i]) begin
            n_checks++;
            $display("FAIL %s.%s: check for cycle %0d never reached", sb[i].tag,
                     sig_name(sb[i].sig), sb[i].cyc);
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
